// File: rtl/print_uart_pkg.sv
// rtl/print_uart_pkg.sv - shared types and constants for the print UART transmitter
// Optional feature macro: UART_PARITY_EN (adds the even-parity bit and PARITY state)
package print_uart_pkg;

  // Frame sequencer states; PARITY only exists in the parity build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned DEFAULT_CLK_DIV = 868;
  localparam logic        LINE_IDLE       = 1'b1;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/print_fifo.sv
// rtl/print_fifo.sv - synchronous byte FIFO with occupancy level
// Ports: clk, resetn (async active-low); push/wr_data write a byte unless full;
//        pop discards the head unless empty; rd_data shows the head byte;
//        level is occupancy (FIFO_AW+1 bits); full/empty are level decodes.
module print_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [7:0]       wr_data,
  input  logic             pop,
  output logic [7:0]       rd_data,
  output logic [FIFO_AW:0] level,
  output logic             full,
  output logic             empty
);

  localparam int            DEPTH_N = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  logic [7:0]         mem_q [DEPTH_N];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               do_push, do_pop;

  assign full    = (level_q == DEPTH);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Full/empty are judged on the level before the edge, so a push into a
  // full FIFO is dropped even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/print_uart_tx.sv
// rtl/print_uart_tx.sv - buffered UART transmitter fed by the data-memory print port
// Optional feature macro: UART_PARITY_EN (8E1 frames; default build is 8N1)
// Ports: clk, resetn (async active-low); print_valid/print_value push a character;
//        uart_txd serial line (idle high); tx_busy frame active or FIFO non-empty;
//        fifo_level FIFO occupancy; drop_cnt saturating count of dropped characters.
module print_uart_tx
  import print_uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             print_valid,
  input  logic [7:0]       print_value,
  output logic             uart_txd,
  output logic             tx_busy,
  output logic [FIFO_AW:0] fifo_level,
  output logic [15:0]      drop_cnt
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic [15:0] drop_q, drop_d;
`ifdef UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic       fifo_pop;
  logic [7:0] fifo_rd_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       bit_done;

  print_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (print_valid),
    .wr_data (print_value),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bit_done = (cnt_q == DIV_LAST);
  assign uart_txd = txd_q;
  assign tx_busy  = (state_q != IDLE) || (fifo_level != '0);
  assign drop_cnt = drop_q;

  // The line level is registered from the current state, so the start bit
  // appears one cycle after the pop; every bit keeps the same CLK_DIV width.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = LINE_IDLE;
    fifo_pop  = 1'b0;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != IDLE) cnt_d = bit_done ? 16'd0 : cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        txd_d = LINE_IDLE;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        txd_d = shift_q[0];
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        txd_d = parity_q;
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        txd_d = LINE_IDLE;
        if (bit_done) begin
          // Chain straight into the next frame when more bytes are queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_pop) begin
      shift_d = fifo_rd_data;
      cnt_d   = 16'd0;
`ifdef UART_PARITY_EN
      parity_d = even_parity(fifo_rd_data);
`endif
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (print_valid && fifo_full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= LINE_IDLE;
      drop_q    <= '0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      drop_q    <= drop_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_print_uart_tx.sv
// tb/tb_print_uart_tx.sv - directed self-checking bench for print_uart_tx
module tb_print_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 2;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int NS = FRAME_BITS * CLK_DIV;

  logic             clk = 1'b0;
  logic             resetn;
  logic             print_valid;
  logic [7:0]       print_value;
  logic             uart_txd;
  logic             tx_busy;
  logic [FIFO_AW:0] fifo_level;
  logic [15:0]      drop_cnt;

  int passed = 0;
  int total  = 0;

  print_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .print_valid (print_valid),
    .print_value (print_value),
    .uart_txd    (uart_txd),
    .tx_busy     (tx_busy),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] value;
    logic       parity;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Line samples expected at each falling edge of one frame.
  function automatic logic [NS-1:0] exp_samples(input logic [7:0] v, input logic p);
    logic [FRAME_BITS-1:0] bits;
    logic [NS-1:0]         s;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = v[i];
    // Bit 9 is the parity bit in 11-bit frames; in 10-bit frames it is the stop bit.
    bits[9] = (FRAME_BITS == 11) ? p : 1'b1;
    bits[FRAME_BITS-1] = 1'b1;
    for (int b = 0; b < FRAME_BITS; b++)
      for (int k = 0; k < CLK_DIV; k++) s[b*CLK_DIV+k] = bits[b];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] v);
    print_value = v;
    print_valid = 1'b1;
    @(negedge clk);
    print_valid = 1'b0;
  endtask

  // Waits for the start bit, then samples every falling edge of the frame.
  // exp_wait is the falling edge (counted from the call) where the line must first be low.
  task automatic check_frame(input logic [7:0] v, input logic p, input string name, input int exp_wait);
    int            waited = 0;
    logic [NS-1:0] got;
    do begin
      @(negedge clk);
      waited++;
    end while (uart_txd !== 1'b0 && waited < 200);
    if (uart_txd !== 1'b0) begin
      total++;
      $display("FAIL %s start: no start bit within 200 cycles", name);
      return;
    end
    got[0] = uart_txd;
    for (int s = 1; s < NS; s++) begin
      @(negedge clk);
      got[s] = uart_txd;
    end
    chk({name, " frame"}, 64'(got), 64'(exp_samples(v, p)));
    chk({name, " latency"}, 64'(waited), 64'(exp_wait));
  endtask

  vec_t vecs[6];
  vec_t ovf[5];

  initial begin
    logic ok_idle;

    vecs[0] = '{8'h41, 1'b0};
    vecs[1] = '{8'h43, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'hA5, 1'b0};
    vecs[5] = '{8'h80, 1'b1};
    ovf[0]  = '{8'h11, 1'b0};
    ovf[1]  = '{8'h12, 1'b0};
    ovf[2]  = '{8'h13, 1'b1};
    ovf[3]  = '{8'h14, 1'b0};
    ovf[4]  = '{8'h15, 1'b1};

    resetn      = 1'b0;
    print_valid = 1'b0;
    print_value = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset txd", 64'(uart_txd), 64'd1);
    chk("reset busy", 64'(tx_busy), 64'd0);
    chk("reset level", 64'(fifo_level), 64'd0);
    chk("reset drop", 64'(drop_cnt), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Isolated single characters: start bit on the second edge after the strobe.
    for (int i = 0; i < 6; i++) begin
      fork
        send_byte(vecs[i].value);
        check_frame(vecs[i].value, vecs[i].parity, $sformatf("vec%0d", i), 3);
      join
      chk($sformatf("vec%0d idle busy", i), 64'(tx_busy), 64'd0);
      chk($sformatf("vec%0d idle level", i), 64'(fifo_level), 64'd0);
      repeat (3) @(negedge clk);
    end
    chk("single drop", 64'(drop_cnt), 64'd0);

    // Back-to-back: second start bit directly follows the first stop bit.
    fork
      begin
        send_byte(8'h41);
        send_byte(8'h43);
      end
      begin
        check_frame(8'h41, 1'b0, "b2b0", 3);
        check_frame(8'h43, 1'b1, "b2b1", 1);
      end
    join
    repeat (3) @(negedge clk);

    // Overflow of a 4-entry FIFO with six consecutive strobes.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          print_value = 8'h11 + 8'(i);
          print_valid = 1'b1;
          @(negedge clk);
          if (i == 4) chk("ovf peak level", 64'(fifo_level), 64'd4);
        end
        print_valid = 1'b0;
        chk("ovf drop", 64'(drop_cnt), 64'd1);
      end
      check_frame(ovf[0].value, ovf[0].parity, "ovf0", 3);
    join
    for (int i = 1; i < 5; i++)
      check_frame(ovf[i].value, ovf[i].parity, $sformatf("ovf%0d", i), 1);
    chk("ovf end busy", 64'(tx_busy), 64'd0);
    chk("ovf end drop", 64'(drop_cnt), 64'd1);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 with a second byte still queued.
    send_byte(8'h00);
    send_byte(8'h55);
    @(negedge clk);
    chk("rst start bit", 64'(uart_txd), 64'd0);
    repeat (17) @(negedge clk);
    chk("rst bit3 low", 64'(uart_txd), 64'd0);
    chk("rst queued", 64'(fifo_level), 64'd1);
    resetn = 1'b0;
    #1;
    chk("rst txd", 64'(uart_txd), 64'd1);
    chk("rst level", 64'(fifo_level), 64'd0);
    chk("rst busy", 64'(tx_busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    ok_idle = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0) ok_idle = 1'b0;
    end
    chk("rst stays idle", 64'(ok_idle), 64'd1);

    // Drop counter saturation with the FIFO full.
    for (int i = 0; i < 5; i++) begin
      print_value = 8'h30 + 8'(i);
      print_valid = 1'b1;
      @(negedge clk);
    end
    print_valid = 1'b0;
    chk("sat full level", 64'(fifo_level), 64'd4);
    force dut.drop_q = 16'hFFFE;
    @(negedge clk);
    release dut.drop_q;
    @(negedge clk);
    chk("sat preset", 64'(drop_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      print_value = 8'h60 + 8'(i);
      print_valid = 1'b1;
      @(negedge clk);
    end
    print_valid = 1'b0;
    chk("sat drop", 64'(drop_cnt), 64'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/print_uart_tx.md
PRINT_UART_TX -- requirements
Module: print_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868: clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_AW, default 4: log2 of the byte FIFO depth (default 16 entries).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port print_valid  input  1  one-cycle strobe from the data-memory print port.
REQ-006 SHALL have port print_value  input  8  character to transmit; sampled when print_valid=1.
REQ-007 SHALL have port uart_txd  output  1  serial line; idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 SHALL have port fifo_level  output  FIFO_AW+1  current FIFO occupancy.
REQ-010 SHALL have port drop_cnt  output  16  count of characters dropped on FIFO full; saturates at 0xFFFF.

Function
REQ-011 SHALL push print_value into the FIFO at the edge sampling print_valid=1 when fifo_level < 2^FIFO_AW before that edge; there is no same-cycle bypass of a concurrent pop.
REQ-012 SHALL discard the byte when full and increment drop_cnt (saturating); print_valid has no backpressure.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE: uart_txd=1; on FIFO non-empty, pop the head byte into the shift register and go to START.
REQ-015 START: uart_txd=0 for CLK_DIV cycles, then DATA.
REQ-016 DATA: send 8 bits LSB first, each CLK_DIV cycles, using a 3-bit bit index; after bit 7 go to PARITY if enabled, else STOP.
REQ-017 STOP: uart_txd=1 for CLK_DIV cycles; then pop and go to START if FIFO non-empty (no idle gap), else IDLE.
REQ-018 Latency: with FIFO empty and FSM in IDLE, uart_txd SHALL fall on the second rising edge after the edge that samples print_valid.
REQ-019 Bit timing SHALL come from a counter running 0..CLK_DIV-1; each bit lasts exactly CLK_DIV cycles with no drift across frames.
REQ-020 Simultaneous push and pop SHALL leave fifo_level unchanged; pointers SHALL wrap modulo 2^FIFO_AW.
REQ-021 tx_busy SHALL be combinational: (state != IDLE) OR (fifo_level != 0).

Reset
REQ-022 On resetn=0, asynchronously: uart_txd=1, tx_busy=0, fifo_level=0, drop_cnt=0, state=IDLE, counters=0.
REQ-023 Reset mid-frame SHALL abort the frame (line high at once) and discard all FIFO contents.

Configuration
REQ-024 Macro UART_PARITY_EN defined: PARITY state sends the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles; frame is 11 bits.
REQ-025 Macro undefined: PARITY state and its logic are absent; frame is 10 bits (8N1).

Structure
REQ-026 A shared package/header print_uart_pkg SHALL hold FSM state encodings, the default CLK_DIV, and the idle line level.
REQ-027 SHALL instantiate exactly one sub-module, print_fifo: a synchronous byte FIFO with push/pop/level, parameterized by FIFO_AW, using the same clk/resetn.

Verification
REQ-028 CLK_DIV=4, no parity, print 0x41 -> txd low 2 edges after strobe; then 0,1,0,0,0,0,0,1,0,1 (start..stop) at 4 cycles each; 40 cycles; drop_cnt=0.
REQ-029 UART_PARITY_EN, CLK_DIV=4, print 0x41 then 0x43 back-to-back -> parity bits 0 then 1; second start bit directly follows the first stop bit; 88 cycles total.
REQ-030 FIFO_AW=2, 6 strobes on consecutive cycles -> first byte popped 1 cycle later; 5 stored, fifo_level peaks at 4, 1 dropped, drop_cnt=1; all 5 bytes transmitted in order.
REQ-031 Assert resetn low during DATA bit 3 -> txd=1 immediately, fifo_level=0, tx_busy=0; after release txd stays high with no strobes.
REQ-032 Force drop_cnt to 0xFFFE with FIFO full, give 3 more strobes -> drop_cnt holds at 0xFFFF.
